// File: rtl/otp_entry_ctrl.sv
// rtl/otp_entry_ctrl.sv - debounced three-button BCD OTP entry controller
module otp_entry_ctrl #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_next,
    input  logic        btn_clear,
    output logic [15:0] user_otp,
    output logic [1:0]  cur_digit,
    output logic        entry_done,
    output logic        otp_valid
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_LIMIT - 1);

    typedef enum logic {ENTRY, DONE} state_t;

    // Button vectors are ordered {clear, next, inc}
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stb;
    logic [2:0]      prs;
    logic [DB_W-1:0] cnt [3];

    state_t          state;
    state_t          state_nx;
    logic [15:0]     otp_nx;
    logic [1:0]      digit_nx;
    logic            done_nx;
    logic            valid_nx;

    logic            inc_p;
    logic            next_p;
    logic            clr_p;

    assign raw    = {btn_clear, btn_next, btn_inc};
    assign inc_p  = prs[0];
    assign next_p = prs[1];
    assign clr_p  = prs[2];

    // Increment one BCD digit with 9 -> 0 wrap, leaving the other digits untouched
    function automatic logic [15:0] bump_digit(input logic [15:0] v, input logic [1:0] idx);
        logic [15:0] r;
        logic [3:0]  d;
        r = v;
        d = v[{idx, 2'b00} +: 4];
        d = (d == 4'd9) ? 4'd0 : d + 4'd1;
        r[{idx, 2'b00} +: 4] = d;
        return r;
    endfunction

    // Two-flop synchronisers, per-button debounce counters and press pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            stb   <= '0;
            prs   <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                // Pulse only on an accepted rising level; releases are silent
                prs[i] <= sync2[i] & ~stb[i] & (cnt[i] == CNT_MAX);
                if (sync2[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Entry state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENTRY;
            user_otp   <= 16'h0000;
            cur_digit  <= 2'd3;
            entry_done <= 1'b0;
            otp_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            user_otp   <= otp_nx;
            cur_digit  <= digit_nx;
            entry_done <= done_nx;
            otp_valid  <= valid_nx;
        end
    end

    // Next-state logic: clear dominates; inc and next may act on the same edge
    always_comb begin
        state_nx = state;
        otp_nx   = user_otp;
        digit_nx = cur_digit;
        done_nx  = entry_done;
        valid_nx = 1'b0;
        if (clr_p) begin
            state_nx = ENTRY;
            otp_nx   = 16'h0000;
            digit_nx = 2'd3;
            done_nx  = 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (inc_p) begin
                        otp_nx = bump_digit(user_otp, cur_digit);
                    end
                    if (next_p) begin
                        if (cur_digit != 2'd0) begin
                            digit_nx = cur_digit - 2'd1;
                        end else begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            valid_nx = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Entry frozen until clear
                end
                default: begin
                    state_nx = ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otp_entry_ctrl.sv
// tb/tb_otp_entry_ctrl.sv - scoreboard bench for otp_entry_ctrl
module tb_otp_entry_ctrl;

    localparam logic [2:0] INC = 3'b001;
    localparam logic [2:0] NXT = 3'b010;
    localparam logic [2:0] CLR = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] user_otp;
    logic [1:0]  cur_digit;
    logic        entry_done;
    logic        otp_valid;

    typedef struct {
        int          cyc;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   applied = 0;
    int   miscompares = 0;

    otp_entry_ctrl #(.DB_LIMIT(4), .DB_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_inc    (btn_inc),
        .btn_next   (btn_next),
        .btn_clear  (btn_clear),
        .user_otp   (user_otp),
        .cur_digit  (cur_digit),
        .entry_done (entry_done),
        .otp_valid  (otp_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic push_exp(input int c, input logic [15:0] o, input logic [1:0] d,
                            input logic dn, input logic v);
        exp_t e;
        e.cyc = c;
        e.val = {o, d, dn, v};
        sb.push_back(e);
    endtask

    // Hold buttons b clean from the edge after cycle c, release, and let the release settle.
    // With DB_LIMIT=4 an accepted press shows on the outputs at cycle c+7.
    task automatic press(input logic [2:0] b, input logic chg, input logic [15:0] o,
                         input logic [1:0] d, input logic dn, input logic pulse);
        int c;
        @(posedge clk); #1;
        c = cyc;
        {btn_clear, btn_next, btn_inc} = b;
        if (chg) begin
            push_exp(c + 7, o, d, dn, pulse);
            if (pulse) push_exp(c + 8, o, d, dn, 1'b0);
        end
        repeat (8) @(posedge clk);
        #1;
        {btn_clear, btn_next, btn_inc} = 3'b000;
        repeat (8) @(posedge clk);
    endtask

    // Monitor: any output change pops the next expected record and checks value and cycle
    initial begin : monitor
        logic [19:0] prev;
        logic [19:0] cur;
        exp_t        e;
        prev = {16'h0000, 2'd3, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            cur = {user_otp, cur_digit, entry_done, otp_valid};
            if (cur !== prev) begin
                applied++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change (was %h)",
                             cyc, cur, prev);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        miscompares++;
                        $display("FAIL output_change got=%h@%0d required=%h@%0d", cur, cyc, e.val, e.cyc);
                    end
                end
                prev = cur;
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                applied++;
                miscompares++;
                $display("FAIL missing_change got=%h@%0d required=%h@%0d", cur, cyc, e.val, e.cyc);
            end
        end
    end

    initial begin : stim
        int c;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Clean latency and digit 3 wrap
        press(INC, 1'b1, 16'h1000, 2'd3, 1'b0, 1'b0);
        for (int n = 2; n <= 9; n++) press(INC, 1'b1, 16'(n << 12), 2'd3, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);

        // Bounce on next: acceptance restarts from the last toggle
        @(posedge clk); #1;
        c = cyc;
        btn_next = 1'b1;
        @(posedge clk); #1 btn_next = 1'b0;
        @(posedge clk); #1 btn_next = 1'b1;
        @(posedge clk); #1 btn_next = 1'b0;
        @(posedge clk); #1 btn_next = 1'b1;
        push_exp(c + 11, 16'h0000, 2'd2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (8) @(posedge clk);

        // Mid-entry asynchronous reset
        press(INC, 1'b1, 16'h0100, 2'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        push_exp(cyc, 16'h0000, 2'd3, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full entry of 1234
        press(INC, 1'b1, 16'h1000, 2'd3, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h1000, 2'd2, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1100, 2'd2, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1200, 2'd2, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h1200, 2'd1, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1210, 2'd1, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1220, 2'd1, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1230, 2'd1, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h1230, 2'd0, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1231, 2'd0, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1232, 2'd0, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1233, 2'd0, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h1234, 2'd0, 1'b1, 1'b1);

        // Frozen in DONE
        press(INC, 1'b0, 16'h1234, 2'd0, 1'b1, 1'b0);
        press(NXT, 1'b0, 16'h1234, 2'd0, 1'b1, 1'b0);

        // Clear from DONE
        press(CLR, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);

        // inc + next together at digit 0 holding 9
        press(NXT, 1'b1, 16'h0000, 2'd2, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h0000, 2'd1, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0);
        for (int n = 1; n <= 9; n++) press(INC, 1'b1, 16'(n), 2'd0, 1'b0, 1'b0);
        press(INC | NXT, 1'b1, 16'h0000, 2'd0, 1'b1, 1'b1);

        // Clear, then clear + inc together
        press(CLR, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);
        press(INC, 1'b1, 16'h1000, 2'd3, 1'b0, 1'b0);
        press(CLR | INC, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);

        // New entry proceeds normally
        press(INC, 1'b1, 16'h1000, 2'd3, 1'b0, 1'b0);
        press(NXT, 1'b1, 16'h1000, 2'd2, 1'b0, 1'b0);

        repeat (20) @(posedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            applied++;
            miscompares++;
            $display("FAIL leftover_expect required=%h@%0d got=none", e.val, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/otp_entry_ctrl.md
# otp_entry_ctrl

Captures the 4-digit user OTP from three raw push-buttons. Each button is synchronised and debounced before use. A small FSM edits and advances BCD digits. The block drives the 16-bit `user_otp` bus consumed by the OTP display/BCD stage and the comparator, and flags when entry is complete.

## Interface
Parameters:
- `DB_LIMIT`, default 50000: number of consecutive stable cycles required to accept a button level change. Legal range 2 to 2^`DB_W`−1.
- `DB_W`, default 16: width of the debounce counter.

Ports:
- `clk`  in  1  system clock. The only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_inc`  in  1  raw button, active-high, asynchronous to `clk`. Increments the current digit.
- `btn_next`  in  1  raw button, active-high, asynchronous. Advances to the next digit or finishes entry.
- `btn_clear`  in  1  raw button, active-high, asynchronous. Restarts entry.
- `user_otp`  out  16  four BCD digits. Digit 3 is `[15:12]`, digit 0 is `[3:0]`. Registered.
- `cur_digit`  out  2  index of the digit being edited (3 down to 0). Registered.
- `entry_done`  out  1  level, high while in state DONE. Registered.
- `otp_valid`  out  1  single-cycle pulse on entry completion. Registered.

## Operation
- **Per-button front end, identical for all three buttons:**
  - 2-FF synchroniser producing `s`.
  - Debounce counter `cnt[DB_W-1:0]` and accepted level `stb`.
  - When `s == stb`: `cnt <= 0`.
  - When `s != stb` and `cnt == DB_LIMIT-1`: `stb <= s`, `cnt <= 0`.
  - When `s != stb` otherwise: `cnt <= cnt+1`.
  - Registered press pulse `prs <= s & ~stb & (cnt == DB_LIMIT-1)`. This is high for exactly one cycle per accepted 0→1 transition.
  - Releases are debounced but produce no pulse.
- **FSM states:** ENTRY, DONE.
- **ENTRY:**
  - `inc` press: `user_otp` digit[`cur_digit`] <= (digit == 9) ? 0 : digit+1. Other digits unchanged. Non-BCD values cannot arise.
  - `next` press with `cur_digit` ≠ 0: `cur_digit <= cur_digit-1`.
  - `next` press with `cur_digit` == 0: go to DONE, `entry_done <= 1`, `otp_valid <= 1` for one cycle. `cur_digit` stays 0.
- **DONE:**
  - `user_otp` is frozen.
  - `inc` and `next` presses are ignored. `otp_valid` never re-fires.
- **`clear` press in any state:** `user_otp <= 0`, `cur_digit <= 3`, `entry_done <= 0`, next state ENTRY.
- **Simultaneous press pulses in the same cycle:**
  - `clear` wins over everything.
  - `inc` + `next` in ENTRY: the increment applies to the current digit, then the block advances, both on the same edge. If `cur_digit` == 0, the increment is applied and DONE is entered.
- **Reset (any time, including mid-debounce or mid-entry):**
  - All synchronisers, `stb`, `cnt` and `prs` go to 0.
  - `user_otp` = 16'h0000, `cur_digit` = 3, `entry_done` = 0, `otp_valid` = 0, state ENTRY.
  - A button held high through reset release is accepted as a press after the normal debounce delay.

## Timing
- Raw input first sampled high at edge k, held clean:
  - `s` is high after edge k+1.
  - `stb` and `prs` are high after edge k+DB_LIMIT+1.
  - `user_otp`, `cur_digit`, `entry_done` and `otp_valid` update after edge k+DB_LIMIT+2.
- Any bounce (s toggling) before `cnt` reaches DB_LIMIT−1 clears `cnt`. The acceptance window restarts from the last toggle.
- `otp_valid` is high for exactly one clock. `entry_done` rises on the same edge.
- Minimum spacing between accepted presses of one button: 2·DB_LIMIT cycles (press debounce plus release debounce).
- All outputs are direct register outputs. There is no combinational path from any input.

## Test plan
Run the bench with DB_LIMIT=4.
1. **Reset:** assert `rst_n` low mid-operation → `user_otp`=0000, `cur_digit`=3, `entry_done`=0, `otp_valid`=0 immediately (asynchronous).
2. **Clean latency:** raw `btn_inc` goes high at edge k and is held → `user_otp`=1000 after edge k+6, not before. Release and press 9 more times → digit 3 wraps 9→0, `user_otp`=0000.
3. **Bounce rejection:** `btn_next` toggles 1,0,1,0 on successive cycles, then holds high for 3 cycles → no press, `cur_digit` stays 3. Holding high a further 4 cycles → `cur_digit`=2.
4. **Full entry:** enter digits 1,2,3,4 with `next` after each → `user_otp`=16'h1234. `otp_valid` pulses exactly once, `entry_done`=1. Further `inc`/`next` presses → no change.
5. **Simultaneous events:**
   - `inc` + `next` accepted on the same cycle at `cur_digit`=0 with digit 0 = 9 → digit 0 becomes 0 and DONE is entered.
   - `clear` + `inc` together → `user_otp`=0000, `cur_digit`=3.
6. **Clear from DONE:** after item 4, press `clear` → `entry_done`=0, `user_otp`=0000, `cur_digit`=3. A new entry then proceeds normally.
